// File: rtl/melangeur_cfg_sequencer.sv
// melangeur_cfg_sequencer
// AXI4-Lite master that programs the melangeur register bank from a
// parallel configuration image after a single start pulse. Registers are
// written one at a time, register 0 first. A watchdog aborts any AXI wait
// that does not complete in time.
// Optional feature macro: MELANGEUR_CFG_READBACK_EN. When it is defined,
// every register is read back after the last write and compared with the
// captured image.

module melangeur_cfg_sequencer #(
    parameter int                    NUM_REGS       = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [NUM_REGS*32-1:0]  cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err_code,
    output logic [3:0]              err_index,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [31:0]             M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [31:0]             M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int         WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
`ifdef MELANGEUR_CFG_READBACK_EN
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
`endif
        S_DONE    = 3'd5
    } state_t;

    state_t                 state;
    logic [NUM_REGS*32-1:0] image;
    logic [3:0]             idx;
    logic [WD_W-1:0]        wd;
    logic                   in_wait;
    logic                   progress;
    logic                   wd_expired;
    logic                   aw_pending;
    logic                   w_pending;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = 4'hF;

    // A channel is still pending if its VALID is up and the slave has not taken it this cycle.
    assign aw_pending = M_AXI_AWVALID && !M_AXI_AWREADY;
    assign w_pending  = M_AXI_WVALID && !M_AXI_WREADY;
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [3:0] i);
        return BASE_ADDR + ADDR_WIDTH'({i, 2'b00});
    endfunction

    function automatic logic [31:0] reg_data(input logic [3:0] i);
        return image[{i, 5'b00000} +: 32];
    endfunction

    // Classify the current state: is it waiting on the slave, and does the slave complete the wait now.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        in_wait  = 1'b0;
        progress = 1'b0;
        case (state)
            S_WR_REQ: begin
                in_wait  = 1'b1;
                progress = !aw_pending && !w_pending;
            end
            S_WR_RESP: begin
                in_wait  = 1'b1;
                progress = M_AXI_BVALID;
            end
`ifdef MELANGEUR_CFG_READBACK_EN
            S_RD_REQ: begin
                in_wait  = 1'b1;
                progress = M_AXI_ARREADY;
            end
            S_RD_RESP: begin
                in_wait  = 1'b1;
                progress = M_AXI_RVALID;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer FSM: all AXI and status outputs are registered here.
    always_ff @(posedge ACLK or posedge ARESET) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (ARESET) begin
            state         <= S_IDLE;
            image         <= '0;
            idx           <= '0;
            wd            <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_code      <= 2'd0;
            err_index     <= 4'd0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
`ifdef MELANGEUR_CFG_READBACK_EN
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
`endif
        end else if (in_wait && !progress && wd_expired) begin
            // Watchdog abort: drop every handshake signal and report where it stalled.
            err_code      <= 2'd3;
            err_index     <= idx;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
`ifdef MELANGEUR_CFG_READBACK_EN
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
`endif
            wd            <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= S_DONE;
        end else begin
            done <= 1'b0;
            if (in_wait && !progress) wd <= wd + 1'b1;
            else                      wd <= '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        image         <= cfg_data;
                        err_code      <= 2'd0;
                        err_index     <= 4'd0;
                        idx           <= 4'd0;
                        busy          <= 1'b1;
                        M_AXI_AWADDR  <= reg_addr(4'd0);
                        M_AXI_WDATA   <= cfg_data[31:0];
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if (progress) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP[1]) begin
                            err_code  <= 2'd1;
                            err_index <= idx;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else if (idx == LAST_IDX) begin
`ifdef MELANGEUR_CFG_READBACK_EN
                            idx           <= 4'd0;
                            M_AXI_ARADDR  <= reg_addr(4'd0);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_REQ;
`else
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= S_DONE;
`endif
                        end else begin
                            idx           <= idx + 4'd1;
                            M_AXI_AWADDR  <= reg_addr(idx + 4'd1);
                            M_AXI_WDATA   <= reg_data(idx + 4'd1);
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= S_WR_REQ;
                        end
                    end
                end
`ifdef MELANGEUR_CFG_READBACK_EN
                S_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (M_AXI_RRESP[1] || (M_AXI_RDATA != reg_data(idx))) begin
                            err_code  <= M_AXI_RRESP[1] ? 2'd1 : 2'd2;
                            err_index <= idx;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx           <= idx + 4'd1;
                            M_AXI_ARADDR  <= reg_addr(idx + 4'd1);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_REQ;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MELANGEUR_CFG_READBACK_EN
    logic unused_resp;
    assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};
`else
    // Read channel is not built: outputs parked, inputs deliberately ignored.
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_BRESP[0], M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

endmodule

// File: tb/tb_melangeur_cfg_sequencer.sv
// tb_melangeur_cfg_sequencer
// Self-checking bench: a behavioural AXI4-Lite slave with per-transaction
// delays and fault injection, and a reference model that lists the
// transactions and final status each configuration run must produce.
// Honours MELANGEUR_CFG_READBACK_EN the same way the design does.

module tb_melangeur_cfg_sequencer;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TMO  = 16;
`ifdef MELANGEUR_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          start = 1'b0;
    logic [N*32-1:0] cfg_data = '0;
    logic          busy, done;
    logic [1:0]    err_code;
    logic [3:0]    err_index;
    logic [31:0]   M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [31:0]   rdata = '0;

    melangeur_cfg_sequencer #(
        .NUM_REGS(N), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err_code(err_code), .err_index(err_index),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scenario knobs (written by the stimulus, read by slave and model)
    logic [31:0] img [N];
    int  aw_dly [16], w_dly [16], b_dly [16], ar_dly [16], r_dly [16];
    int  berr_idx = -1, corrupt_idx = -1;
    bit  aw_stuck = 1'b0, hold_chk_en = 1'b1;

    // Observed traffic (written by the slave)
    logic [31:0] got_aw [$], got_w [$], got_ar [$];
    logic [31:0] mem [N];

    // Expected traffic (written by the model)
    logic [31:0] exp_aw [$], exp_w [$], exp_ar [$];
    logic [1:0]  exp_code;
    logic [3:0]  exp_idx;

    // Slave state
    int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, wr_i, rd_i, sk;
    bit  aw_got, w_got, b_pend, r_pend;
    logic [31:0] r_addr;
    logic p_busy, p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
    logic p_arvalid, p_arready, p_rvalid, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    // Behavioural AXI4-Lite slave, evaluated on the falling edge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            p_busy = 0; p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0;
            p_bvalid = 0; p_bready = 0; p_arvalid = 0; p_arready = 0; p_rvalid = 0; p_rready = 0;
            p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        end else begin
            if (busy && !p_busy) begin
                got_aw.delete(); got_w.delete(); got_ar.delete();
                for (int i = 0; i < N; i++) mem[i] = 32'h0;
                wr_i = 0; rd_i = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; bvalid = 0; rvalid = 0;
            end
            // Handshakes completed at the rising edge just passed
            if (p_awvalid && p_awready) begin got_aw.push_back(p_awaddr); aw_got = 1; end
            if (p_wvalid && p_wready) begin got_w.push_back(p_wdata); w_got = 1; end
            if (p_bvalid && p_bready) begin bvalid = 0; wr_i++; end
            if (p_arvalid && p_arready) begin got_ar.push_back(p_araddr); r_addr = p_araddr; r_pend = 1; r_cnt = 0; end
            if (p_rvalid && p_rready) begin rvalid = 0; rd_i++; end
            if (hold_chk_en) begin
                if (p_awvalid && !p_awready)
                    check("aw_hold", {31'b0, M_AXI_AWVALID, M_AXI_AWADDR}, {32'd1, p_awaddr});
                if (p_wvalid && !p_wready)
                    check("w_hold", {31'b0, M_AXI_WVALID, M_AXI_WDATA}, {32'd1, p_wdata});
                if (p_arvalid && !p_arready)
                    check("ar_hold", {31'b0, M_AXI_ARVALID, M_AXI_ARADDR}, {32'd1, p_araddr});
            end
            if (aw_got && w_got) begin
                sk = int'((got_aw[$] - BASE) >> 2);
                if (sk >= 0 && sk < N) mem[sk] = got_w[$];
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            if (b_pend) begin
                if (b_cnt >= b_dly[wr_i]) begin
                    bvalid = 1; bresp = (wr_i == berr_idx) ? 2'b10 : 2'b00; b_pend = 0;
                end else b_cnt++;
            end
            if (r_pend) begin
                if (r_cnt >= r_dly[rd_i]) begin
                    sk = int'((r_addr - BASE) >> 2);
                    rdata = (sk >= 0 && sk < N) ? mem[sk] : 32'hBAD0_BAD0;
                    if (rd_i == corrupt_idx) rdata = 32'hDEAD_BEEF;
                    rresp = 2'b00; rvalid = 1; r_pend = 0;
                end else r_cnt++;
            end
            if (!M_AXI_AWVALID) begin awready = 0; aw_cnt = 0; end
            else if (!aw_stuck && aw_cnt >= aw_dly[wr_i]) awready = 1;
            else begin awready = 0; aw_cnt++; end
            if (!M_AXI_WVALID) begin wready = 0; w_cnt = 0; end
            else if (w_cnt >= w_dly[wr_i]) wready = 1;
            else begin wready = 0; w_cnt++; end
            if (!M_AXI_ARVALID) begin arready = 0; ar_cnt = 0; end
            else if (ar_cnt >= ar_dly[rd_i]) arready = 1;
            else begin arready = 0; ar_cnt++; end
            p_busy = busy;
            p_awvalid = M_AXI_AWVALID; p_awready = awready; p_awaddr = M_AXI_AWADDR;
            p_wvalid = M_AXI_WVALID; p_wready = wready; p_wdata = M_AXI_WDATA;
            p_bvalid = bvalid; p_bready = M_AXI_BREADY;
            p_arvalid = M_AXI_ARVALID; p_arready = arready; p_araddr = M_AXI_ARADDR;
            p_rvalid = rvalid; p_rready = M_AXI_RREADY;
        end
    end

    // Reference model: the transactions a run must issue and its final status.
    task automatic build_model();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        exp_code = 2'd0; exp_idx = 4'd0;
        if (aw_stuck) begin
            exp_w.push_back(img[0]);
            exp_code = 2'd3;
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_aw.push_back(BASE + 32'(4 * i));
                exp_w.push_back(img[i]);
                if (i == berr_idx) begin exp_code = 2'd1; exp_idx = 4'(i); break; end
            end
            if (RB && exp_code == 2'd0) begin
                for (int i = 0; i < N; i++) begin
                    exp_ar.push_back(BASE + 32'(4 * i));
                    if (i == corrupt_idx && img[i] != 32'hDEAD_BEEF) begin
                        exp_code = 2'd2; exp_idx = 4'(i); break;
                    end
                end
            end
        end
    endtask

    task automatic random_delays();
        for (int i = 0; i < 16; i++) begin
            aw_dly[i] = $urandom_range(0, 4); w_dly[i] = $urandom_range(0, 4);
            b_dly[i]  = $urandom_range(0, 4); ar_dly[i] = $urandom_range(0, 4);
            r_dly[i]  = $urandom_range(0, 4);
        end
    endtask

    task automatic random_image();
        for (int i = 0; i < N; i++) img[i] = $urandom;
    endtask

    task automatic load_cfg();
        for (int i = 0; i < N; i++) cfg_data[32*i +: 32] = img[i];
    endtask

    task automatic run_case(input string name, input bit timeout_case);
        int n;
        build_model();
        @(negedge ACLK);
        load_cfg();
        start = 1'b1;
        @(negedge ACLK);
        check({name, ".busy"}, busy, 1);
        // A start while busy and a changing cfg_data must both be ignored
        start = 1'b1;
        cfg_data = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!done && n < 400) begin
            @(negedge ACLK);
            start = 1'b0;
            n++;
        end
        check({name, ".done_seen"}, done, 1);
        if (timeout_case) check({name, ".timeout_latency"}, n, TMO);
        check({name, ".err_code"}, err_code, exp_code);
        check({name, ".err_index"}, err_index, exp_idx);
        check({name, ".busy_low"}, busy, 0);
        check({name, ".handshakes_idle"},
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
        @(negedge ACLK);
        check({name, ".done_pulse"}, done, 0);
        check({name, ".err_held"}, {err_code, err_index}, {exp_code, exp_idx});
        check({name, ".aw_count"}, got_aw.size(), exp_aw.size());
        check({name, ".w_count"}, got_w.size(), exp_w.size());
        check({name, ".ar_count"}, got_ar.size(), exp_ar.size());
        for (int i = 0; i < exp_aw.size() && i < got_aw.size(); i++)
            check($sformatf("%s.awaddr%0d", name, i), got_aw[i], exp_aw[i]);
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s.wdata%0d", name, i), got_w[i], exp_w[i]);
        for (int i = 0; i < exp_ar.size() && i < got_ar.size(); i++)
            check($sformatf("%s.araddr%0d", name, i), got_ar[i], exp_ar[i]);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            aw_dly[i] = 0; w_dly[i] = 0; b_dly[i] = 0; ar_dly[i] = 0; r_dly[i] = 0;
        end
        for (int i = 0; i < N; i++) img[i] = 32'h0;

        // Power-on reset
        repeat (3) @(negedge ACLK);
        check("reset.status", {busy, done, err_code, err_index}, 8'h00);
        check("reset.handshakes",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
        check("reset.awaddr_wdata", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
        check("reset.araddr", M_AXI_ARADDR, 32'h0);
        check("const.prot_strb", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, {3'b000, 3'b000, 4'hF});
        ARESET = 1'b0;

        // Basic sequence, image 1..4, zero-wait slave
        for (int i = 0; i < N; i++) img[i] = 32'(i + 1);
        run_case("basic", 1'b0);

        // AW accepted well before W on write 0, reversed on write 1
        random_image(); random_delays();
        aw_dly[0] = 0; w_dly[0] = 3; aw_dly[1] = 3; w_dly[1] = 0;
        run_case("skew", 1'b0);

        // Slave error response on register 2
        random_image(); random_delays();
        berr_idx = 2;
        run_case("bresp_err", 1'b0);
        berr_idx = -1;

        // Corrupted readback data for register 1
        random_image(); random_delays();
        corrupt_idx = 1;
        run_case("readback_corrupt", 1'b0);
        corrupt_idx = -1;

        // AWREADY never asserted: watchdog abort
        random_image(); random_delays();
        aw_stuck = 1'b1; hold_chk_en = 1'b0;
        run_case("timeout", 1'b1);
        aw_stuck = 1'b0; hold_chk_en = 1'b1;

        // Asynchronous reset while waiting on a write response
        random_image(); random_delays();
        b_dly[0] = 8;
        @(negedge ACLK);
        load_cfg();
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        n = 0;
        while (!M_AXI_BREADY && n < 50) begin @(negedge ACLK); n++; end
        check("midreset.in_wr_resp", M_AXI_BREADY, 1);
        #2 ARESET = 1'b1;
        #1;
        check("midreset.async_clear",
              {busy, done, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 7'b0);
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        random_delays();
        run_case("after_reset", 1'b0);

        // Randomized clean runs
        for (int k = 0; k < 3; k++) begin
            random_image(); random_delays();
            run_case($sformatf("rand%0d", k), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/melangeur_cfg_sequencer.md
Name: melangeur_cfg_sequencer

Overview:
- AXI4-Lite master that programs the melangeur register bank (NUM_REGS x 32-bit slave registers at 4-byte stride) from a parallel configuration vector after a single start pulse.
- Issues sequential single-beat writes, reg 0 first, then optionally reads every register back and compares.
- Reports done, error class and failing register index.
- Sits between system control logic and the melangeur S00_AXI port; replaces software/VIP-driven bring-up.

Parameters:
- NUM_REGS, 4, number of consecutive 32-bit registers programmed (1..16).
- BASE_ADDR, 32'h0000_0000, byte address of register 0; register i at BASE_ADDR + 4*i.
- ADDR_WIDTH, 32, M_AXI address width.
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting in any single AXI wait state before abort; 0 disables the watchdog.

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- cfg_data  in  NUM_REGS*32  register images, reg i at bits [32*i+31:32*i]; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until entry to DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- err_code  out  2  0 none, 1 slave SLVERR/DECERR, 2 readback mismatch, 3 timeout; held until next accepted start.
- err_index  out  4  register index of first error; held with err_code.
- M_AXI_AWADDR  out  ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_WIDTH
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset (async assert, sync release): state IDLE; all VALID/READY outputs 0; busy 0; done 0; err_code 0; err_index 0; AWADDR/ARADDR/WDATA 0; index counter 0; watchdog 0. Outstanding AXI transfers are abandoned; slave is reset in the same domain.
- Registered outputs only; no combinational input-to-output paths.
- States:
  - IDLE/DONE: start=1 -> capture cfg_data, clear err_code/err_index, index=0, go WR_REQ.
  - WR_REQ: AWVALID and WVALID asserted together, AWADDR = BASE_ADDR+4*index, WDATA = image[index]. Each VALID drops independently on its own handshake (AW/W accepted in either order or same cycle). When both accepted -> WR_RESP.
  - WR_RESP: BREADY=1. On BVALID: BRESP[1]=1 -> err_code=1, err_index=index, go DONE. Otherwise, if index==NUM_REGS-1 go RD_REQ (feature on) or DONE; else index+1, WR_REQ.
  - RD_REQ: ARVALID=1, ARADDR as above; on ARREADY -> RD_RESP.
  - RD_RESP: RREADY=1. On RVALID: RRESP[1]=1 -> code 1; RDATA != image[index] -> code 2; either -> DONE. Else last index -> DONE, else index+1, RD_REQ.
- Exactly one AXI transaction outstanding at any time; VALID never drops before its handshake.
- Watchdog: counts cycles in a wait state, cleared on every state change. When it reaches TIMEOUT_CYCLES: err_code=3, err_index=index, deassert all VALID/READY, go DONE.
- DONE: busy 0, done pulses one cycle on entry, then remains in DONE. start in DONE behaves as in IDLE.
- start while busy: ignored; captured image unaffected by later cfg_data changes.
- NUM_REGS=1: single write (and single read), index never increments.

Optional Feature:
- MELANGEUR_CFG_READBACK_EN defined: RD_REQ/RD_RESP compiled in; full readback verification after the last write.
- Undefined: read states, AR/R logic and code 2 removed; ARVALID and RREADY tied 0, ARADDR 0; DONE follows the last successful write.

Test Plan:
- Reset, cfg_data={4,3,2,1}, start -> writes addr 0x0/0x4/0x8/0xC with data 1/2/3/4, reads return same; done pulse, err_code 0, busy low.
- Slave AWREADY 3 cycles before WREADY, then reversed on next write -> each VALID held until own handshake; data and addresses unchanged.
- BRESP=2'b10 on register 2 write -> no further AXI traffic, err_code 1, err_index 2, done pulse.
- With readback, slave returns 0xDEAD_BEEF for register 1 -> err_code 2, err_index 1.
- AWREADY stuck low, TIMEOUT_CYCLES=16 -> abort 16 cycles after WR_REQ entry, err_code 3, err_index 0, all VALIDs 0.
- ARESET asserted mid WR_RESP -> same-cycle async clear of all VALID/READY/busy; a subsequent start performs the full sequence cleanly.
